// File: rtl/mdp_snd_out.sv
// rtl/mdp_snd_out.sv - MDP PCM / console audio gain-mix with saturation and 3-wire left-justified DAC serializer
module mdp_snd_out #(
    parameter int BCK_DIV = 8,
    parameter int GAIN_SH = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               next_sample,
    input  logic signed [15:0] pcm_l,
    input  logic signed [15:0] pcm_r,
    input  logic signed [15:0] md_l,
    input  logic signed [15:0] md_r,
    input  logic        [7:0]  pcm_gain,
    input  logic        [7:0]  md_gain,
    input  logic               mute,
    input  logic               ovr_clr,
    output logic signed [15:0] mix_l,
    output logic signed [15:0] mix_r,
    output logic               i2s_bck,
    output logic               i2s_lrck,
    output logic               i2s_sd,
    output logic               busy,
    output logic               ovr
);

    localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    function automatic logic signed [24:0] gain_mul(input logic signed [15:0] x,
                                                    input logic [7:0] g);
        logic signed [24:0] xe;
        logic signed [24:0] ge;
        xe = 25'(x);
        ge = $signed({17'd0, g});
        return xe * ge;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767)
            return 16'sh7fff;
        else if (v < -26'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    logic               ns_d1;
    logic               ns_d2;
    logic               mute_r;
    logic signed [24:0] prod_pl;
    logic signed [24:0] prod_pr;
    logic signed [24:0] prod_ml;
    logic signed [24:0] prod_mr;

    logic signed [25:0] sum_l;
    logic signed [25:0] sum_r;
    logic signed [25:0] sh_l;
    logic signed [25:0] sh_r;
    logic signed [15:0] nxt_l;
    logic signed [15:0] nxt_r;

    state_t             state;
    logic        [31:0] shreg;
    logic        [4:0]  slot;
    logic        [DW-1:0] div;
    logic               ph;
    logic               load;

    // Stage 1: strobe delay and gain multiply; the inputs settle one clk after next_sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            ns_d1   <= 1'b0;
            ns_d2   <= 1'b0;
            mute_r  <= 1'b0;
            prod_pl <= '0;
            prod_pr <= '0;
            prod_ml <= '0;
            prod_mr <= '0;
        end else begin
            ns_d1 <= next_sample;
            ns_d2 <= ns_d1;
            if (ns_d1) begin
                prod_pl <= gain_mul(pcm_l, pcm_gain);
                prod_pr <= gain_mul(pcm_r, pcm_gain);
                prod_ml <= gain_mul(md_l, md_gain);
                prod_mr <= gain_mul(md_r, md_gain);
                mute_r  <= mute;
            end
        end
    end

    // Stage 2 datapath: sum, arithmetic shift (floor), saturate, mute.
    always_comb begin
        sum_l = 26'(prod_pl) + 26'(prod_ml);
        sum_r = 26'(prod_pr) + 26'(prod_mr);
        sh_l  = sum_l >>> GAIN_SH;
        sh_r  = sum_r >>> GAIN_SH;
        nxt_l = mute_r ? 16'sd0 : sat16(sh_l);
        nxt_r = mute_r ? 16'sd0 : sat16(sh_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mix_l <= '0;
            mix_r <= '0;
        end else if (ns_d2) begin
            mix_l <= nxt_l;
            mix_r <= nxt_r;
        end
    end

    // The frame loads the same edge mix updates, so the shifter takes the pre-register value.
    assign load = ns_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            slot     <= '0;
            div      <= '0;
            ph       <= 1'b0;
            i2s_bck  <= 1'b0;
            i2s_lrck <= 1'b0;
            i2s_sd   <= 1'b0;
            busy     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (load && state == SHIFT)
                ovr <= 1'b1;
            else if (ovr_clr)
                ovr <= 1'b0;

            case (state)
                IDLE: begin
                    if (load) begin
                        shreg    <= {nxt_l, nxt_r};
                        i2s_sd   <= nxt_l[15];
                        i2s_lrck <= 1'b0;
                        i2s_bck  <= 1'b0;
                        slot     <= '0;
                        div      <= '0;
                        ph       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (!ph) begin
                            ph      <= 1'b1;
                            i2s_bck <= 1'b1;
                        end else begin
                            ph      <= 1'b0;
                            i2s_bck <= 1'b0;
                            if (slot == 5'd31) begin
                                state    <= IDLE;
                                i2s_lrck <= 1'b0;
                                i2s_sd   <= 1'b0;
                                busy     <= 1'b0;
                            end else begin
                                // Slot boundary: data and word select move while bck is low.
                                slot     <= slot + 5'd1;
                                i2s_lrck <= (slot >= 5'd15);
                                i2s_sd   <= shreg[30];
                                shreg    <= {shreg[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdp_snd_out.sv
// tb/tb_mdp_snd_out.sv - directed self-checking bench for mdp_snd_out
module tb_mdp_snd_out;

    logic               clk;
    logic               rst;
    logic               next_sample;
    logic signed [15:0] pcm_l, pcm_r, md_l, md_r;
    logic        [7:0]  pcm_gain, md_gain;
    logic               mute, ovr_clr;

    logic signed [15:0] mix_l2, mix_r2, mix_l8, mix_r8;
    logic bck2, lrck2, sd2, busy2, ovr2;
    logic bck8, lrck8, sd8, busy8, ovr8;

    logic sel8;
    wire  bck_s  = sel8 ? bck8  : bck2;
    wire  lrck_s = sel8 ? lrck8 : lrck2;
    wire  sd_s   = sel8 ? sd8   : sd2;
    wire  busy_s = sel8 ? busy8 : busy2;

    int n_checks;
    int n_fail;

    mdp_snd_out #(.BCK_DIV(2), .GAIN_SH(7)) u_dut2 (
        .clk(clk), .rst(rst), .next_sample(next_sample),
        .pcm_l(pcm_l), .pcm_r(pcm_r), .md_l(md_l), .md_r(md_r),
        .pcm_gain(pcm_gain), .md_gain(md_gain), .mute(mute), .ovr_clr(ovr_clr),
        .mix_l(mix_l2), .mix_r(mix_r2), .i2s_bck(bck2), .i2s_lrck(lrck2),
        .i2s_sd(sd2), .busy(busy2), .ovr(ovr2)
    );

    mdp_snd_out #(.BCK_DIV(8), .GAIN_SH(7)) u_dut8 (
        .clk(clk), .rst(rst), .next_sample(next_sample),
        .pcm_l(pcm_l), .pcm_r(pcm_r), .md_l(md_l), .md_r(md_r),
        .pcm_gain(pcm_gain), .md_gain(md_gain), .mute(mute), .ovr_clr(ovr_clr),
        .mix_l(mix_l8), .mix_r(mix_r8), .i2s_bck(bck8), .i2s_lrck(lrck8),
        .i2s_sd(sd8), .busy(busy8), .ovr(ovr8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1;
        next_sample = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse;
        @(negedge clk);
        next_sample = 1'b1;
        @(negedge clk);
        next_sample = 1'b0;
    endtask

    // Samples at negedges; records sd/lrck on each bck rise, busy cycles and rise spacing.
    task automatic capture_frame(input bit use8, input int max_cycles, input int stop_edges,
                                 input int inj_at, input logic [15:0] inj_pcm_l,
                                 output logic [31:0] sd_bits, output logic [31:0] lr_bits,
                                 output int edges, output int busy_cnt, output int bad_period);
        logic prev;
        int   last_rise;
        int   per;
        sel8 = use8;
        per = use8 ? 16 : 4;
        sd_bits = '0; lr_bits = '0; edges = 0; busy_cnt = 0; bad_period = 0;
        prev = 1'b0; last_rise = 0;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            if (c == inj_at) begin
                next_sample = 1'b1;
                pcm_l = inj_pcm_l;
            end else begin
                next_sample = 1'b0;
            end
            if (busy_s) busy_cnt++;
            if (bck_s && !prev) begin
                if (edges > 0 && (c - last_rise) != per) bad_period++;
                last_rise = c;
                edges++;
                sd_bits = {sd_bits[30:0], sd_s};
                lr_bits = {lr_bits[30:0], lrck_s};
            end
            prev = bck_s;
            if (stop_edges > 0 && edges == stop_edges) break;
        end
        next_sample = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        n_checks++; if (mix_l8 !== 16'sd0) begin n_fail++; $display("FAIL reset_mix_l: got %0d expected 0", mix_l8); end
        n_checks++; if (mix_r8 !== 16'sd0) begin n_fail++; $display("FAIL reset_mix_r: got %0d expected 0", mix_r8); end
        n_checks++; if ({bck8, lrck8, sd8} !== 3'b000) begin n_fail++; $display("FAIL reset_serial: got %b expected 000", {bck8, lrck8, sd8}); end
        n_checks++; if ({busy8, ovr8, busy2, ovr2} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy8, ovr8, busy2, ovr2}); end
    endtask

    task automatic test_unity;
        apply_reset();
        pcm_l = 16'sd1000; md_l = 16'sd0; pcm_r = 16'sd0; md_r = 16'sd0;
        pcm_gain = 8'd128; md_gain = 8'd128;
        pulse();
        @(negedge clk);
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL unity_busy_early: got %b expected 0", busy8); end
        @(negedge clk);
        n_checks++; if (mix_l8 !== 16'sd1000) begin n_fail++; $display("FAIL unity_mix_l: got %0d expected 1000", mix_l8); end
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL unity_busy: got %b expected 1", busy8); end
        n_checks++; if (mix_l2 !== 16'sd1000) begin n_fail++; $display("FAIL unity_mix_l_div2: got %0d expected 1000", mix_l2); end
    endtask

    task automatic test_saturation;
        apply_reset();
        pcm_l = 16'sd30000; md_l = 16'sd10000; pcm_r = -16'sd30000; md_r = -16'sd10000;
        pcm_gain = 8'd128; md_gain = 8'd128;
        pulse(); repeat (2) @(negedge clk);
        n_checks++; if (mix_l8 !== 16'sh7fff) begin n_fail++; $display("FAIL sat_pos: got %0d expected 32767", mix_l8); end
        n_checks++; if (mix_r8 !== 16'sh8000) begin n_fail++; $display("FAIL sat_neg: got %0d expected -32768", mix_r8); end
        pcm_l = 16'sd30000; pcm_gain = 8'd0; md_l = 16'sd500; md_gain = 8'd128;
        pulse(); repeat (2) @(negedge clk);
        n_checks++; if (mix_l8 !== 16'sd500) begin n_fail++; $display("FAIL gain_zero: got %0d expected 500", mix_l8); end
        pcm_l = 16'sd100; pcm_gain = 8'd255; md_gain = 8'd0;
        pulse(); repeat (2) @(negedge clk);
        n_checks++; if (mix_l8 !== 16'sd199) begin n_fail++; $display("FAIL gain_255: got %0d expected 199", mix_l8); end
    endtask

    task automatic test_floor_mute;
        apply_reset();
        pcm_l = -16'sd3; pcm_gain = 8'd64; md_l = 16'sd0; md_gain = 8'd128;
        pcm_r = 16'sd77; md_r = 16'sd0; mute = 1'b0;
        pulse(); repeat (2) @(negedge clk);
        n_checks++; if (mix_l8 !== -16'sd2) begin n_fail++; $display("FAIL floor_round: got %0d expected -2", mix_l8); end
        n_checks++; if (mix_r8 !== 16'sd38) begin n_fail++; $display("FAIL floor_pos: got %0d expected 38", mix_r8); end
        mute = 1'b1;
        pulse(); repeat (2) @(negedge clk);
        mute = 1'b0;
        n_checks++; if (mix_l8 !== 16'sd0 || mix_r8 !== 16'sd0) begin n_fail++; $display("FAIL mute: got %0d/%0d expected 0/0", mix_l8, mix_r8); end
    endtask

    task automatic test_serial;
        logic [31:0] sdb, lrb;
        int e, bc, bad;
        apply_reset();
        pcm_l = 16'hA5A5; pcm_r = 16'h0F0F; md_l = 16'sd0; md_r = 16'sd0;
        pcm_gain = 8'd128; md_gain = 8'd0;
        pulse();
        capture_frame(1'b0, 300, 0, -1, 16'h0000, sdb, lrb, e, bc, bad);
        n_checks++; if (sdb !== 32'hA5A50F0F) begin n_fail++; $display("FAIL serial_data: got %h expected a5a50f0f", sdb); end
        n_checks++; if (lrb !== 32'h0000FFFF) begin n_fail++; $display("FAIL serial_lrck: got %h expected 0000ffff", lrb); end
        n_checks++; if (e !== 32) begin n_fail++; $display("FAIL serial_edges: got %0d expected 32", e); end
        n_checks++; if (bc !== 128) begin n_fail++; $display("FAIL serial_busy_len: got %0d expected 128", bc); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL serial_bck_period: got %0d bad periods expected 0", bad); end
        n_checks++; if ({bck2, lrck2, sd2, busy2} !== 4'b0000) begin n_fail++; $display("FAIL serial_idle: got %b expected 0000", {bck2, lrck2, sd2, busy2}); end
    endtask

    task automatic test_overrun;
        logic [31:0] sdb, lrb;
        int e, bc, bad;
        apply_reset();
        pcm_l = 16'hA5A5; pcm_r = 16'h0F0F; md_l = 16'sd0; md_r = 16'sd0;
        pcm_gain = 8'd128; md_gain = 8'd0;
        pulse();
        capture_frame(1'b1, 700, 0, 99, 16'h1234, sdb, lrb, e, bc, bad);
        n_checks++; if (sdb !== 32'hA5A50F0F) begin n_fail++; $display("FAIL ovr_first_frame: got %h expected a5a50f0f", sdb); end
        n_checks++; if (e !== 32 || bc !== 512) begin n_fail++; $display("FAIL ovr_no_second: got edges %0d busy %0d expected 32/512", e, bc); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ovr_bck_period: got %0d expected 0", bad); end
        n_checks++; if (ovr8 !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ovr8); end
        n_checks++; if (mix_l8 !== 16'sh1234) begin n_fail++; $display("FAIL ovr_mix_updates: got %h expected 1234", mix_l8); end
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        n_checks++; if (ovr8 !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b expected 0", ovr8); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] sdb, lrb;
        int e, bc, bad;
        apply_reset();
        pcm_l = 16'hA5A5; pcm_r = 16'h0F0F; md_l = 16'sd0; md_r = 16'sd0;
        pcm_gain = 8'd128; md_gain = 8'd0;
        pulse();
        capture_frame(1'b1, 400, 11, 20, 16'hA5A5, sdb, lrb, e, bc, bad);
        n_checks++; if ({bck8, sd8, ovr8, busy8} !== 4'b1111 || e !== 11) begin n_fail++; $display("FAIL mid_pre: got bck/sd/ovr/busy %b edges %0d expected 1111 11", {bck8, sd8, ovr8, busy8}, e); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({bck8, lrck8, sd8, busy8, ovr8} !== 5'b00000) begin n_fail++; $display("FAIL mid_reset: got %b expected 00000", {bck8, lrck8, sd8, busy8, ovr8}); end
        rst = 1'b0;
        pcm_l = 16'h3C5A; pcm_r = 16'hC3A5;
        pulse();
        capture_frame(1'b1, 700, 0, -1, 16'h0000, sdb, lrb, e, bc, bad);
        n_checks++; if (sdb !== 32'h3C5AC3A5) begin n_fail++; $display("FAIL mid_new_data: got %h expected 3c5ac3a5", sdb); end
        n_checks++; if (lrb !== 32'h0000FFFF) begin n_fail++; $display("FAIL mid_new_lrck: got %h expected 0000ffff", lrb); end
        n_checks++; if (e !== 32 || bc !== 512) begin n_fail++; $display("FAIL mid_new_len: got edges %0d busy %0d expected 32/512", e, bc); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0; next_sample = 1'b0; sel8 = 1'b1;
        pcm_l = '0; pcm_r = '0; md_l = '0; md_r = '0;
        pcm_gain = 8'd128; md_gain = 8'd128; mute = 1'b0; ovr_clr = 1'b0;
        test_reset();
        test_unity();
        test_saturation();
        test_floor_mute();
        test_serial();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
